alu_sequencer: RTL and testbench

Synchronous front-end that issues operations to the combinational 16-bit ALU and returns its results. Requests arrive on a valid/ready handshake. The sequencer drives registered operands and opcode onto the ALU, waits a fixed settle time, captures C/vout/cout, and queues the result in a small in-order response FIFO with its own valid/ready handshake. It sits between any master (test sequencer, datapath controller) and the `alu` instance, and flags undefined opcodes without issuing them.

---
 rtl/alu_sequencer.sv | 147 ++++++++++++++
 tb/tb_alu_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Valid/ready front-end for the combinational 16-bit ALU: registers a request onto the ALU,
// waits a fixed settle time, captures the result and queues it in an in-order response FIFO.
module alu_sequencer #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 2,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [4:0]       req_code,
  input  logic             req_coe,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_code,
  output logic             alu_coe,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_vout,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_vout,
  output logic             rsp_cout,
  output logic             rsp_illegal,
  output logic [15:0]      op_count
);

  localparam int CNT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = WIDTH + 3;

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [PTR_W:0]   DEPTH_CNT   = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   settle_cnt;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;

  logic               accept;
  logic               code_legal;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] push_entry;

  function automatic logic is_legal(input logic [4:0] code);
    case (code)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
      5'b01000, 5'b01001, 5'b01010, 5'b01100,
      5'b10000, 5'b10001, 5'b10010, 5'b10011,
      5'b11000, 5'b11001, 5'b11010, 5'b11011, 5'b11100, 5'b11101:
        is_legal = 1'b1;
      default:
        is_legal = 1'b0;
    endcase
  endfunction

  // Only one operation is ever in flight, so gating acceptance on free space
  // guarantees the FIFO can never be pushed while full.
  assign req_ready  = (state == S_IDLE) && (count < DEPTH_CNT);
  assign accept     = req_valid && req_ready;
  assign code_legal = is_legal(req_code);

  // Illegal codes bypass the ALU and are answered with a flagged all-zero entry.
  assign push       = (state == S_CAPTURE) || (accept && !code_legal);
  assign push_entry = (state == S_CAPTURE) ? {alu_c, alu_vout, alu_cout, 1'b0}
                                           : {{WIDTH{1'b0}}, 1'b0, 1'b0, 1'b1};

  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_code   <= '0;
      alu_coe    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && code_legal) begin
            alu_a      <= req_a;
            alu_b      <= req_b;
            alu_code   <= req_code;
            alu_coe    <= req_coe;
            settle_cnt <= SETTLE_LOAD;
            if (SETTLE == 1) state <= S_CAPTURE;
            else             state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) state <= S_CAPTURE;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
        S_CAPTURE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      op_count <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        op_count <= op_count + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign {rsp_c, rsp_vout, rsp_cout, rsp_illegal} = rsp_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU attached to its alu_* port.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [4:0]  req_code;
  logic        req_coe;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [4:0]  alu_code;
  logic        alu_coe;
  logic [15:0] alu_c;
  logic        alu_vout;
  logic        alu_cout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_c;
  logic        rsp_vout;
  logic        rsp_cout;
  logic        rsp_illegal;
  logic [15:0] op_count;

  int checks   = 0;
  int failures = 0;

  alu_sequencer #(.WIDTH(16), .SETTLE(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_code(req_code), .req_coe(req_coe),
    .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code), .alu_coe(alu_coe),
    .alu_c(alu_c), .alu_vout(alu_vout), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_c(rsp_c), .rsp_vout(rsp_vout), .rsp_cout(rsp_cout), .rsp_illegal(rsp_illegal),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU covering the opcodes exercised here; carry out is gated by active-low coe.
  logic [16:0] wide;
  logic        ovf;
  always_comb begin
    wide = '0;
    ovf  = 1'b0;
    case (alu_code)
      5'b00000, 5'b00001: begin
        wide = {1'b0, alu_a} + {1'b0, alu_b};
        ovf  = (alu_a[15] == alu_b[15]) && (wide[15] != alu_a[15]);
      end
      5'b00010, 5'b00011: begin
        wide = {1'b0, alu_a} - {1'b0, alu_b};
        ovf  = (alu_a[15] != alu_b[15]) && (wide[15] != alu_a[15]);
      end
      5'b00100: wide = {1'b0, alu_a} + 17'd1;
      5'b00101: wide = {1'b0, alu_a} - 17'd1;
      5'b01000: wide = {1'b0, alu_a & alu_b};
      5'b01001: wide = {1'b0, alu_a | alu_b};
      5'b01010: wide = {1'b0, alu_a ^ alu_b};
      5'b01100: wide = {1'b0, ~alu_a};
      default:  wide = '0;
    endcase
    alu_c    = wide[15:0];
    alu_cout = !alu_coe && wide[16];
    alu_vout = ovf;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents one request and returns right after the edge at which it was accepted.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic [4:0] code, input logic coe);
    int n = 0;
    req_a     = a;
    req_b     = b;
    req_code  = code;
    req_coe   = coe;
    req_valid = 1'b1;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    checkOutput("req_ready_wait", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic waitRsp(output int ticks);
    ticks = 0;
    while (!rsp_valid && ticks < 50) begin
      tick();
      ticks++;
    end
    checkOutput("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic expectRsp(input string tag, input logic [15:0] c, input logic v,
                           input logic co, input logic ill);
    int t;
    waitRsp(t);
    checkOutput({tag, "_c"}, {16'd0, rsp_c}, {16'd0, c});
    checkOutput({tag, "_vout"}, {31'd0, rsp_vout}, {31'd0, v});
    checkOutput({tag, "_cout"}, {31'd0, rsp_cout}, {31'd0, co});
    checkOutput({tag, "_illegal"}, {31'd0, rsp_illegal}, {31'd0, ill});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int t1;
    int t2;
    int lows;
    int highs;
    int accepted;
    int pops;
    int guard;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_code  = '0;
    req_coe   = 1'b1;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset_op_count", {16'd0, op_count}, 32'd0);
    checkOutput("reset_alu_a", {16'd0, alu_a}, 32'd0);
    checkOutput("reset_rsp_c", {16'd0, rsp_c}, 32'd0);

    // ADD with latency and operand-register checks
    applyStimulus(16'hA00A, 16'h1004, 5'b00000, 1'b0);
    checkOutput("add_alu_a", {16'd0, alu_a}, 32'h0000A00A);
    checkOutput("add_alu_b", {16'd0, alu_b}, 32'h00001004);
    checkOutput("add_busy_ready", {31'd0, req_ready}, 32'd0);
    waitRsp(lat);
    checkOutput("add_latency", lat, 32'd3);
    checkOutput("add_op_count", {16'd0, op_count}, 32'd1);
    expectRsp("add", 16'hB00E, 1'b0, 1'b0, 1'b0);

    // Flag capture: unsigned carry and signed overflow land on distinct outputs
    applyStimulus(16'hFFFF, 16'h0001, 5'b00000, 1'b0);
    expectRsp("add_carry", 16'h0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'h7FFF, 16'h0001, 5'b00000, 1'b0);
    expectRsp("add_ovf", 16'h8000, 1'b1, 1'b0, 1'b0);

    // SUB then AND with req_valid held high
    req_a = 16'h8012; req_b = 16'h8002; req_code = 5'b00010; req_coe = 1'b0;
    req_valid = 1'b1;
    tick();
    t1 = 0;
    req_a = 16'hF14A; req_b = 16'hF002; req_code = 5'b01000;
    lows = 0;
    while (!req_ready && lows < 20) begin
      tick();
      lows++;
    end
    checkOutput("b2b_ready_low_cycles", lows, 32'd3);
    tick();
    t2 = lows + 1;
    req_valid = 1'b0;
    checkOutput("b2b_accept_spacing", t2 - t1, 32'd4);
    expectRsp("b2b_sub", 16'h0010, 1'b0, 1'b0, 1'b0);
    expectRsp("b2b_and", 16'hF002, 1'b0, 1'b0, 1'b0);

    // Illegal opcode answered next cycle without touching the ALU registers
    applyStimulus(16'h1234, 16'h5678, 5'b00110, 1'b0);
    checkOutput("ill_latency_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("ill_alu_code_kept", {27'd0, alu_code}, 32'h08);
    checkOutput("ill_alu_a_kept", {16'd0, alu_a}, 32'h0000F14A);
    expectRsp("ill", 16'h0000, 1'b0, 1'b0, 1'b1);

    // Backpressure: four incs fill the FIFO, the fifth waits for a pop
    for (int i = 0; i < 4; i++) applyStimulus(16'(i), 16'h0000, 5'b00100, 1'b1);
    req_a = 16'h0004; req_b = 16'h0000; req_code = 5'b00100; req_coe = 1'b1;
    req_valid = 1'b1;
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      if (req_ready) highs++;
      tick();
    end
    checkOutput("bp_ready_stays_low", highs, 32'd0);
    expectRsp("bp_0", 16'h0001, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_ready_after_pop", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    expectRsp("bp_1", 16'h0002, 1'b0, 1'b0, 1'b0);
    expectRsp("bp_2", 16'h0003, 1'b0, 1'b0, 1'b0);
    expectRsp("bp_3", 16'h0004, 1'b0, 1'b0, 1'b0);
    expectRsp("bp_4", 16'h0005, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_op_count", {16'd0, op_count}, 32'd11);

    // Reset while the add is settling: nothing may emerge afterwards
    applyStimulus(16'h0001, 16'h0001, 5'b00000, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_mid_op_count", {16'd0, op_count}, 32'd0);
    checkOutput("rst_mid_alu_a", {16'd0, alu_a}, 32'd0);
    checkOutput("rst_mid_alu_code", {27'd0, alu_code}, 32'd0);
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) highs++;
      tick();
    end
    checkOutput("rst_mid_no_rsp", highs, 32'd0);

    // op_count wrap via 65536 back-to-back illegal requests with continuous draining
    req_a = '0; req_b = '0; req_code = 5'b00110;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    accepted = 0;
    pops = 0;
    guard = 0;
    while (accepted < 65536 && guard < 70000) begin
      if (req_ready) accepted++;
      if (rsp_valid) pops++;
      tick();
      guard++;
      if (accepted == 65535 && req_ready)
        checkOutput("wrap_op_count_ffff", {16'd0, op_count}, 32'h0000FFFF);
      if (accepted == 65536) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) pops++;
      tick();
    end
    rsp_ready = 1'b0;
    checkOutput("wrap_accepted", accepted, 32'd65536);
    checkOutput("wrap_op_count", {16'd0, op_count}, 32'd0);
    checkOutput("wrap_pops", pops, 32'd65536);
    checkOutput("wrap_drained", {31'd0, rsp_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
